block_swap_seq: RTL and testbench

BLOCK_SWAP_SEQ -- requirements
Module: block_swap_seq

---
 rtl/block_swap_seq.sv | 187 ++++++++++++++++++
 tb/tb_block_swap_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_swap_seq.sv
// Block swap sequencer: evicts one SRAM slot to backing memory, then refills it with a new block.
// Writeback of the evicted block is compiled in only when BLOCK_SWAP_WRITEBACK_EN is defined.

module block_swap_seq #(
    parameter int          BLOCK_WORDS = 16,
    parameter int          NUM_SLOTS   = 4,
    parameter logic [31:0] MEM_BASE    = 32'h1000_0000,
    localparam int         IDX_W       = $clog2(NUM_SLOTS),
    localparam int         OFF_W       = $clog2(BLOCK_WORDS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   swap_req_i,
    input  logic [IDX_W-1:0]       old_addr_idx_i,
    input  logic [20:0]            old_addr_i,
    input  logic [20:0]            new_addr_i,
    output logic                   done_o,
    output logic                   busy_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [IDX_W+OFF_W-1:0] sram_addr_o,
    output logic [31:0]            sram_wdata_o,
    input  logic [31:0]            sram_rdata_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [31:0]            mem_rdata_i
);

    // state  | meaning
    // IDLE   | waiting for swap_req_i
    // WB_RD  | one-cycle SRAM read of the word to evict
    // WB_REQ | memory write request held until granted
    // WB_RSP | waiting for the write response
    // FE_REQ | memory read request held until granted
    // FE_RSP | waiting for read data, written straight into SRAM
    // DONE   | one-cycle completion pulse
`ifdef BLOCK_SWAP_WRITEBACK_EN
    typedef enum logic [2:0] {IDLE, WB_RD, WB_REQ, WB_RSP, FE_REQ, FE_RSP, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, FE_REQ, FE_RSP, DONE} state_t;
`endif

    localparam logic [20:0]      EMPTY_ADDR = 21'h1F_FFFF;
    localparam logic [OFF_W-1:0] LAST_WORD  = OFF_W'(BLOCK_WORDS - 1);
    localparam logic [31:0]      BW32       = 32'(BLOCK_WORDS);

    state_t           state_q;
    logic [IDX_W-1:0] slot_q;
    logic [20:0]      new_q;
    logic [OFF_W-1:0] cnt_q;

    function automatic logic [31:0] word_addr(input logic [20:0] blk, input logic [OFF_W-1:0] off);
        return MEM_BASE + ((32'(blk) * BW32 + 32'(off)) << 2);
    endfunction

`ifdef BLOCK_SWAP_WRITEBACK_EN
    logic [20:0] old_q;
    logic        sram_rd_q;
    logic        wb_live_q;
    logic [31:0] wdata_q;

    // SRAM data arrives in the first WB_REQ cycle; it is forwarded then and held afterwards.
    assign mem_wdata_o = wb_live_q ? sram_rdata_i : wdata_q;
    assign sram_req_o  = sram_rd_q | sram_we_o;
`else
    assign mem_wdata_o = '0;
    assign sram_req_o  = sram_we_o;
`endif

    assign sram_we_o    = (state_q == FE_RSP) && mem_rvalid_i;
    assign sram_addr_o  = {slot_q, cnt_q};
    assign sram_wdata_o = sram_we_o ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            new_q      <= '0;
            cnt_q      <= '0;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
`ifdef BLOCK_SWAP_WRITEBACK_EN
            old_q      <= '0;
            sram_rd_q  <= 1'b0;
            wb_live_q  <= 1'b0;
            wdata_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (swap_req_i) begin
                        slot_q <= old_addr_idx_i;
                        new_q  <= new_addr_i;
                        cnt_q  <= '0;
                        busy_o <= 1'b1;
`ifdef BLOCK_SWAP_WRITEBACK_EN
                        old_q  <= old_addr_i;
                        if (old_addr_i != EMPTY_ADDR) begin
                            state_q   <= WB_RD;
                            sram_rd_q <= 1'b1;
                        end else begin
                            state_q    <= FE_REQ;
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= word_addr(new_addr_i, '0);
                        end
`else
                        state_q    <= FE_REQ;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= word_addr(new_addr_i, '0);
`endif
                    end
                end
`ifdef BLOCK_SWAP_WRITEBACK_EN
                WB_RD: begin
                    sram_rd_q  <= 1'b0;
                    wb_live_q  <= 1'b1;
                    mem_req_o  <= 1'b1;
                    mem_we_o   <= 1'b1;
                    mem_addr_o <= word_addr(old_q, cnt_q);
                    state_q    <= WB_REQ;
                end
                WB_REQ: begin
                    wb_live_q <= 1'b0;
                    if (wb_live_q) begin
                        wdata_q <= sram_rdata_i;
                    end
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        state_q   <= WB_RSP;
                    end
                end
                WB_RSP: begin
                    if (mem_rvalid_i) begin
                        if (cnt_q == LAST_WORD) begin
                            cnt_q      <= '0;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= word_addr(new_q, '0);
                            state_q    <= FE_REQ;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            sram_rd_q <= 1'b1;
                            state_q   <= WB_RD;
                        end
                    end
                end
`endif
                FE_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= FE_RSP;
                    end
                end
                FE_RSP: begin
                    if (mem_rvalid_i) begin
                        if (cnt_q == LAST_WORD) begin
                            cnt_q   <= '0;
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q      <= cnt_q + 1'b1;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= word_addr(new_q, cnt_q + 1'b1);
                            state_q    <= FE_REQ;
                        end
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_swap_seq.sv
// Directed bench for block_swap_seq; writeback expectations follow BLOCK_SWAP_WRITEBACK_EN.

module tb_block_swap_seq;

    localparam int IDX_W = 2;
    localparam int AW    = 6;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          swap_req_i = 1'b0;
    logic [IDX_W-1:0] old_addr_idx_i = '0;
    logic [20:0]   old_addr_i = '0;
    logic [20:0]   new_addr_i = '0;
    logic          done_o, busy_o;
    logic          sram_req_o, sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_wdata_o;
    logic [31:0]   sram_rdata_i = '0;
    logic          mem_req_o, mem_we_o;
    logic [31:0]   mem_addr_o, mem_wdata_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [31:0]   mem_rdata_i = '0;

    block_swap_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .swap_req_i(swap_req_i),
        .old_addr_idx_i(old_addr_idx_i), .old_addr_i(old_addr_i), .new_addr_i(new_addr_i),
        .done_o(done_o), .busy_o(busy_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    logic        gnt_pend = 1'b0;
    logic        pend_we = 1'b0;
    logic [31:0] pend_addr = '0;
    int          stall_left = 0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_req_cycles, n_we_cycles, n_gnt, done_cnt;
    int          n_rd, n_wr, n_sw, n_sr;
    int          done_at [4];
    logic [31:0] rd_log [64];
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];
    logic [31:0] sw_addr_log [64];
    logic [31:0] sw_data_log [64];
    logic [31:0] sr_addr_log [64];

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] sram_pat(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Memory and SRAM responder plus transaction logger, all on the falling edge.
    always @(negedge clk_i) begin
        cyc++;
        if (!rst_ni) begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            gnt_pend     = 1'b0;
        end else begin
            mem_rvalid_i = gnt_pend;
            mem_rdata_i  = (gnt_pend && !pend_we) ? rd_pat(pend_addr) : 32'hDEAD_BEEF;
            if (mem_req_o && mem_addr_o == stall_addr) stall_req_cycles++;
            if (mem_req_o && mem_we_o) n_we_cycles++;
            if (mem_req_o && stall_left > 0 && mem_addr_o == stall_addr) begin
                mem_gnt_i = 1'b0;
                stall_left--;
            end else begin
                mem_gnt_i = mem_req_o;
            end
            if (mem_gnt_i) begin
                gnt_pend  = 1'b1;
                pend_addr = mem_addr_o;
                pend_we   = mem_we_o;
                n_gnt++;
                if (mem_we_o) begin
                    if (n_wr < 64) begin
                        wr_addr_log[n_wr] = mem_addr_o;
                        wr_data_log[n_wr] = mem_wdata_o;
                    end
                    n_wr++;
                end else begin
                    if (n_rd < 64) rd_log[n_rd] = mem_addr_o;
                    n_rd++;
                end
            end else begin
                gnt_pend = 1'b0;
            end
        end
        #1;
        if (rst_ni && sram_req_o && !sram_we_o) begin
            sram_rdata_i = sram_pat(sram_addr_o);
            if (n_sr < 64) sr_addr_log[n_sr] = 32'(sram_addr_o);
            n_sr++;
        end
        if (sram_req_o && sram_we_o) begin
            if (n_sw < 64) begin
                sw_addr_log[n_sw] = 32'(sram_addr_o);
                sw_data_log[n_sw] = sram_wdata_o;
            end
            n_sw++;
        end
        if (done_o) begin
            if (done_cnt < 4) done_at[done_cnt] = cyc;
            done_cnt++;
        end
    end

    task automatic clear_logs();
        stall_req_cycles = 0; n_we_cycles = 0; n_gnt = 0; done_cnt = 0;
        n_rd = 0; n_wr = 0; n_sw = 0; n_sr = 0;
        stall_left = 0; stall_addr = 32'hFFFF_FFFF;
    endtask

    task automatic start_swap(input logic [IDX_W-1:0] slot, input logic [20:0] old_a,
                              input logic [20:0] new_a, output int acc);
        int n = 0;
        @(negedge clk_i); #2;
        while (busy_o && n < 500) begin
            @(negedge clk_i); #2;
            n++;
        end
        if (busy_o) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy_o=%b, required 0", busy_o);
        end
        swap_req_i = 1'b1; old_addr_idx_i = slot; old_addr_i = old_a; new_addr_i = new_a;
        acc = cyc;
        @(negedge clk_i); #2;
        swap_req_i = 1'b0; old_addr_idx_i = ~slot; old_addr_i = 21'h0A5A5; new_addr_i = 21'h01234;
    endtask

    task automatic wait_done(input int want);
        int n = 0;
        while (done_cnt < want && n < 300) begin
            @(negedge clk_i); #2;
            n++;
        end
        if (done_cnt < want) begin
            checks++; errors++;
            $display("FAIL done_timeout: got %0d pulses, required %0d", done_cnt, want);
        end
        repeat (6) @(negedge clk_i);
        #2;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] base, input int slot, input int acc,
                               input int lat);
        checks++;
        if (n_rd !== 16) begin errors++; $display("FAIL %s_nreads: got %0d, required 16", tag, n_rd); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (rd_log[k] !== base + 32'(4 * k)) begin
                errors++;
                $display("FAIL %s_raddr[%0d]: got %h, required %h", tag, k, rd_log[k], base + 32'(4 * k));
            end
        end
        checks++;
        if (n_sw !== 16) begin errors++; $display("FAIL %s_nsram_wr: got %0d, required 16", tag, n_sw); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (sw_addr_log[k] !== 32'(slot * 16 + k) || sw_data_log[k] !== rd_pat(base + 32'(4 * k))) begin
                errors++;
                $display("FAIL %s_sram_wr[%0d]: got addr %0d data %h, required addr %0d data %h", tag, k,
                         sw_addr_log[k], sw_data_log[k], slot * 16 + k, rd_pat(base + 32'(4 * k)));
            end
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL %s_done_count: got %0d, required 1", tag, done_cnt); end
        checks++;
        if (done_at[0] - acc !== lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d, required %0d", tag, done_at[0] - acc, lat);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        #2;
        checks++;
        if ({done_o, busy_o, sram_req_o, sram_we_o, mem_req_o, mem_we_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {done_o, busy_o, sram_req_o, sram_we_o, mem_req_o, mem_we_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, sram_wdata_o, 26'(sram_addr_o)} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got maddr %h mwdata %h swdata %h saddr %h, required 0",
                     mem_addr_o, mem_wdata_o, sram_wdata_o, sram_addr_o);
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_empty_slot();
        int acc;
        clear_logs();
        start_swap(2'd1, 21'h1F_FFFF, 21'h00000, acc);
        wait_done(1);
        checks++;
        if (n_wr !== 0 || n_we_cycles !== 0) begin
            errors++;
            $display("FAIL empty_no_writes: got %0d writes, required 0", n_wr);
        end
        check_fetch("empty", 32'h1000_0000, 1, acc, 33);
    endtask

`ifdef BLOCK_SWAP_WRITEBACK_EN
    task automatic test_writeback();
        int acc;
        clear_logs();
        start_swap(2'd2, 21'h00003, 21'h00005, acc);
        wait_done(1);
        checks++;
        if (n_wr !== 16 || n_sr !== 16) begin
            errors++;
            $display("FAIL wb_counts: got %0d writes %0d sram reads, required 16 and 16", n_wr, n_sr);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (wr_addr_log[k] !== 32'h1000_00C0 + 32'(4 * k) || wr_data_log[k] !== sram_pat(AW'(32 + k))
                || sr_addr_log[k] !== 32'(32 + k)) begin
                errors++;
                $display("FAIL wb_word[%0d]: got addr %h data %h sram %0d, required %h %h %0d", k,
                         wr_addr_log[k], wr_data_log[k], sr_addr_log[k],
                         32'h1000_00C0 + 32'(4 * k), sram_pat(AW'(32 + k)), 32 + k);
            end
        end
        check_fetch("wb", 32'h1000_0140, 2, acc, 81);
    endtask
`else
    task automatic test_no_writeback();
        int acc;
        clear_logs();
        start_swap(2'd2, 21'h00003, 21'h00005, acc);
        wait_done(1);
        checks++;
        if (n_we_cycles !== 0 || n_wr !== 0 || n_sr !== 0) begin
            errors++;
            $display("FAIL nowb_writes: got %0d we cycles %0d writes %0d sram reads, required 0",
                     n_we_cycles, n_wr, n_sr);
        end
        check_fetch("nowb", 32'h1000_0140, 2, acc, 33);
    endtask
`endif

    task automatic test_high_addr();
        int acc;
        clear_logs();
        start_swap(2'd3, 21'h1F_FFFF, 21'h1F_FFFE, acc);
        wait_done(1);
        check_fetch("high", 32'h17FF_FF80, 3, acc, 33);
    endtask

    task automatic test_gnt_stall();
        int acc;
        clear_logs();
        stall_addr = 32'h1000_009C;
        stall_left = 5;
        start_swap(2'd3, 21'h1F_FFFF, 21'h00002, acc);
        wait_done(1);
        checks++;
        if (stall_req_cycles !== 6) begin
            errors++;
            $display("FAIL stall_addr_cycles: got %0d, required 6", stall_req_cycles);
        end
        check_fetch("stall", 32'h1000_0080, 3, acc, 38);
    endtask

    task automatic test_reset_mid_swap();
        int acc;
        int n = 0;
        clear_logs();
        start_swap(2'd1, 21'h00003, 21'h00006, acc);
        while (!(n_gnt == 5 && !mem_req_o) && n < 200) begin
            @(negedge clk_i); #2;
            n++;
        end
        checks++;
        if (n_gnt != 5) begin errors++; $display("FAIL rstmid_reach: got %0d grants, required 5", n_gnt); end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({done_o, busy_o, sram_req_o, sram_we_o, mem_req_o, mem_we_o} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl: got %b, required 000000",
                     {done_o, busy_o, sram_req_o, sram_we_o, mem_req_o, mem_we_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, sram_wdata_o, 26'(sram_addr_o)} !== 128'b0) begin
            errors++;
            $display("FAIL rstmid_data: got maddr %h mwdata %h swdata %h saddr %h, required 0",
                     mem_addr_o, mem_wdata_o, sram_wdata_o, sram_addr_o);
        end
        repeat (2) @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        repeat (60) @(negedge clk_i);
        #2;
        checks++;
        if (done_cnt !== 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_dropped: got %0d done pulses busy %b, required 0 and 0", done_cnt, busy_o);
        end
        clear_logs();
        start_swap(2'd0, 21'h1F_FFFF, 21'h00007, acc);
        wait_done(1);
        check_fetch("rstmid_after", 32'h1000_01C0, 0, acc, 33);
    endtask

    task automatic test_back_to_back();
        int acc;
        int n = 0;
        clear_logs();
        @(negedge clk_i); #2;
        swap_req_i = 1'b1; old_addr_idx_i = 2'd0; old_addr_i = 21'h1F_FFFF; new_addr_i = 21'h00008;
        acc = cyc;
        while (done_cnt < 2 && n < 300) begin
            @(negedge clk_i); #2;
            n++;
        end
        swap_req_i = 1'b0;
        checks++;
        if (done_cnt < 2) begin errors++; $display("FAIL b2b_timeout: got %0d pulses, required 2", done_cnt); end
        repeat (50) @(negedge clk_i);
        #2;
        checks++;
        if (done_at[0] - acc !== 33) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d, required 33", done_at[0] - acc);
        end
        checks++;
        if (done_at[1] - done_at[0] !== 34) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d, required 34", done_at[1] - done_at[0]);
        end
        checks++;
        if (done_cnt !== 2 || n_rd !== 32) begin
            errors++;
            $display("FAIL b2b_count: got %0d done %0d reads, required 2 and 32", done_cnt, n_rd);
        end
        checks++;
        if (rd_log[16] !== 32'h1000_0200 || rd_log[31] !== 32'h1000_023C) begin
            errors++;
            $display("FAIL b2b_second_addr: got %h..%h, required 10000200..1000023c", rd_log[16], rd_log[31]);
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_empty_slot();
`ifdef BLOCK_SWAP_WRITEBACK_EN
        test_writeback();
`else
        test_no_writeback();
`endif
        test_high_addr();
        test_gnt_stall();
        test_reset_mid_swap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
